// File: rtl/uart_pkg.sv
// Shared types and default constants for the FIFO-to-UART drain path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // 50 MHz CLOCK_50 divided down to 115200 baud
   localparam int CLKS_PER_BIT_50M_115200 = 434;
   localparam int UART_DATA_WIDTH         = 8;

endpackage

// File: rtl/baud_counter.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while clear is high, so every bit time starts aligned to the
// cycle that clear drops.
module baud_counter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign tick = !clear && (cnt == LAST);

   // wrap on the terminal count so the next state starts its bit at 0
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clear || tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops the 16x8 FIFO one entry at a time and serializes each entry as a UART
// frame (start, LSB-first data, optional even parity, 1 or 2 stop bits).
// read, tx and done are decoded from the registered state, so a reset drops
// the line high in the same cycle it is asserted.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = UART_DATA_WIDTH,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_115200,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] outputBus,
   output logic                  read,
   output logic                  tx,
   output logic                  busy,
   output logic                  done,
   output logic [7:0]            frame_count
);

   // bit counter also counts stop bits, which never exceeds DATA_WIDTH
   localparam int            BW        = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   tx_state_t             state, state_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic                  par_q, par_n;
   logic [BW-1:0]         bit_cnt, bit_cnt_n;
   logic                  tick;

   // counter idles at zero so START gets a full bit time after the pop
   baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .reset(reset),
      .clear(state == IDLE),
      .tick (tick)
   );

   assign busy = (state != IDLE);

   // next-state, datapath updates and line outputs
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      par_n     = par_q;
      bit_cnt_n = bit_cnt;
      read      = 1'b0;
      tx        = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            // reset gates the pop so no entry is consumed while held
            if (enable && !empty && !reset) begin
               read      = 1'b1;
               shreg_n   = outputBus;
               par_n     = ^outputBus;
               bit_cnt_n = '0;
               state_n   = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (tick)
               state_n = DATA;
         end
         DATA: begin
            tx = shreg[0];
            if (tick) begin
               shreg_n = shreg >> 1;
               if (bit_cnt == LAST_DATA) begin
                  bit_cnt_n = '0;
                  state_n   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_n = bit_cnt + BW'(1);
               end
            end
         end
         PARITY: begin
            tx = par_q;
            if (tick)
               state_n = STOP;
         end
         STOP: begin
            if (tick) begin
               if (bit_cnt == LAST_STOP) begin
                  done      = 1'b1;
                  bit_cnt_n = '0;
                  state_n   = IDLE;
               end else begin
                  bit_cnt_n = bit_cnt + BW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // state, shift register and frame counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         shreg       <= '0;
         par_q       <= 1'b0;
         bit_cnt     <= '0;
         frame_count <= 8'd0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         par_q   <= par_n;
         bit_cnt <= bit_cnt_n;
         if (done)
            frame_count <= frame_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: bytes pushed into a FIFO model also push their expected
// frame; a line decoder on tx pops and compares every frame it sees.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0, reset = 1'b1;
   logic       enable_a = 1'b0, enable_p = 1'b0, empty = 1'b1;
   logic [7:0] outputBus = 8'h00;
   logic       read_a, tx_a, busy_a, done_a, read_p, tx_p, busy_p, done_p;
   logic [7:0] fc_a, fc_p;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .reset(reset), .enable(enable_a), .empty(empty), .outputBus(outputBus),
      .read(read_a), .tx(tx_a), .busy(busy_a), .done(done_a), .frame_count(fc_a));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_p (
      .clk(clk), .reset(reset), .enable(enable_p), .empty(empty), .outputBus(outputBus),
      .read(read_p), .tx(tx_p), .busy(busy_p), .done(done_p), .frame_count(fc_p));

   typedef struct {
      logic [7:0] d;
      logic       p;
   } exp_t;

   logic [7:0] fifo_q[$];
   exp_t       exp_q[$];
   int         n_vec = 0, n_err = 0;
   int         cyc = 0, rd_cnt = 0, done_cnt = 0, last_rd = 0, last_done = 0, prev_rd = -1;
   bit         gap_chk = 1'b0, mon_par = 1'b0;
   logic [7:0] v3 [16] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h6A, 8'h96,
                           8'h3C, 8'hC3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic p, input bit expect_it);
      exp_t e;
      fifo_q.push_back(d);
      if (expect_it) begin
         e.d = d;
         e.p = p;
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done_timeout"}, 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic wait_read(input int target, input int budget, input string name);
      int n = 0;
      while (rd_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_read_timeout"}, 32'(rd_cnt >= target), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // FIFO head presented on the falling edge, stable across the capturing edge
   initial forever begin
      @(negedge clk);
      empty     = (fifo_q.size() == 0);
      outputBus = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   end

   // strobe sampler: pops the FIFO model and timestamps reads and dones
   initial forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (read_a === 1'b1 || read_p === 1'b1) begin
         rd_cnt++;
         chk("read_while_empty", 32'(empty), 32'd0);
         if (fifo_q.size() != 0) void'(fifo_q.pop_front());
         if (gap_chk) begin
            if (prev_rd >= 0) chk("read_gap", 32'(cyc - prev_rd), 32'd41);
            prev_rd = cyc;
         end
         last_rd = cyc;
      end
      if (done_a === 1'b1 || done_p === 1'b1) begin
         done_cnt++;
         last_done = cyc;
      end
   end

   // tx line decoder: samples mid-bit and checks each frame against the scoreboard
   logic [11:0] bits;
   logic        tx_mon;
   bit          mact = 1'b0;
   int          pos = 0, slots;
   initial forever begin
      @(negedge clk);
      #3;
      tx_mon = mon_par ? tx_p : tx_a;
      slots  = mon_par ? 11 : 10;
      if (reset) begin
         mact = 1'b0;
      end else begin
         if (!mact && tx_mon === 1'b0) begin
            mact = 1'b1;
            pos  = 0;
         end
         if (mact) begin
            if (pos % CPB == CPB / 2) bits[pos / CPB] = tx_mon;
            pos++;
            if (pos == slots * CPB) begin
               exp_t e;
               mact = 1'b0;
               chk("start_bit", 32'(bits[0]), 32'd0);
               chk("stop_bit", 32'(bits[slots - 1]), 32'd1);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_frame: got 0x%0h, expected no frame", bits[8:1]);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_data", 32'(bits[8:1]), 32'(e.d));
                  if (mon_par) chk("frame_parity", 32'(bits[9]), 32'(e.p));
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, d0, bad;

      // reset holds everything quiet even with data waiting and enable high
      push(8'h6A, 1'b0, 1'b1);
      enable_a = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_tx", 32'(tx_a), 32'd1);
      chk("rst_read", 32'(read_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_fc", 32'(fc_a), 32'd0);
      chk("rst_read_p", 32'(read_p), 32'd0);

      // single 0x6A frame
      @(negedge clk);
      reset = 1'b0;
      wait_done(1, 200, "s1");
      chk("s1_reads", 32'(rd_cnt), 32'd1);
      chk("s1_len", 32'(last_done - last_rd), 32'd40);
      chk("s1_fc", 32'(fc_a), 32'd1);
      chk("s1_busy", 32'(busy_a), 32'd0);

      // enabled with an empty FIFO: line stays idle
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         #1;
         if (read_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
      end
      chk("s2_idle_bad_cycles", 32'(bad), 32'd0);
      chk("s2_reads", 32'(rd_cnt), 32'd1);

      // sixteen back-to-back frames
      enable_a = 1'b0;
      do_reset();
      for (int i = 0; i < 16; i++) push(v3[i], 1'b0, 1'b1);
      r0 = rd_cnt;
      d0 = done_cnt;
      prev_rd = -1;
      gap_chk = 1'b1;
      enable_a = 1'b1;
      wait_done(d0 + 16, 16 * 41 + 50, "s3");
      gap_chk = 1'b0;
      chk("s3_reads", 32'(rd_cnt - r0), 32'd16);
      chk("s3_fc", 32'(fc_a), 32'd16);
      @(negedge clk);
      #1;
      chk("s3_empty", 32'(empty), 32'd1);
      chk("s3_busy", 32'(busy_a), 32'd0);

      // parity variant
      enable_a = 1'b0;
      do_reset();
      mon_par = 1'b1;
      push(8'h19, 1'b1, 1'b1);
      push(8'h6A, 1'b0, 1'b1);
      d0 = done_cnt;
      enable_p = 1'b1;
      wait_done(d0 + 2, 200, "s4");
      chk("s4_len", 32'(last_done - last_rd), 32'd44);
      chk("s4_fc", 32'(fc_p), 32'd2);
      enable_p = 1'b0;
      repeat (3) @(negedge clk);
      mon_par = 1'b0;

      // enable dropped mid-frame
      do_reset();
      push(8'hC1, 1'b0, 1'b1);
      push(8'h3C, 1'b0, 1'b1);
      r0 = rd_cnt;
      d0 = done_cnt;
      enable_a = 1'b1;
      wait_read(r0 + 1, 50, "s5");
      repeat (17) @(negedge clk);
      enable_a = 1'b0;
      wait_done(d0 + 1, 100, "s5a");
      repeat (20) @(negedge clk);
      chk("s5_no_pop", 32'(rd_cnt - r0), 32'd1);
      chk("s5_busy", 32'(busy_a), 32'd0);
      enable_a = 1'b1;
      #1;
      chk("s5_repop", 32'(read_a), 32'd1);
      wait_done(d0 + 2, 100, "s5b");
      chk("s5_fc", 32'(fc_a), 32'd2);

      // reset mid-frame drops 0xFF
      push(8'hFF, 1'b0, 1'b0);
      push(8'h55, 1'b0, 1'b1);
      r0 = rd_cnt;
      d0 = done_cnt;
      wait_read(r0 + 1, 50, "s6");
      repeat (12) @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("s6_tx", 32'(tx_a), 32'd1);
      chk("s6_busy", 32'(busy_a), 32'd0);
      chk("s6_fc", 32'(fc_a), 32'd0);
      chk("s6_read", 32'(read_a), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_done(d0 + 1, 100, "s6");
      chk("s6_reads", 32'(rd_cnt - r0), 32'd2);
      chk("s6_fc_after", 32'(fc_a), 32'd1);
      enable_a = 1'b0;
      repeat (5) @(negedge clk);
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
